// File: rtl/fir_seq_driver.sv
// System-side controller for a sequential FIR core: serial coefficient load, sample
// streaming and result return. Define FIR_SEQ_DRV_SAT_EN to saturate m_data instead of truncating.
module fir_seq_driver #(
  parameter int unsigned DATA_IN_WIDTH  = 8,
  parameter int unsigned COEF_WIDTH     = 8,
  parameter int unsigned DATA_OUT_WIDTH = 18,
  parameter int unsigned ORDER          = 6,
  parameter int unsigned RESULT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      tc,
  input  logic                      cfg_coef_wr,
  input  logic [COEF_WIDTH-1:0]     cfg_coef_data,
  input  logic                      cfg_commit,
  input  logic                      cfg_stop,
  output logic                      cfg_busy,
  output logic                      cfg_err,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_IN_WIDTH-1:0]  s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [RESULT_WIDTH-1:0]   m_data,
  output logic                      fir_coef_shift_en,
  output logic [COEF_WIDTH-1:0]     fir_coef_in,
  output logic                      fir_tc,
  output logic                      fir_run,
  output logic [DATA_IN_WIDTH-1:0]  fir_data_in,
  output logic [DATA_OUT_WIDTH-1:0] fir_init_acc_val,
  input  logic                      fir_start,
  input  logic                      fir_hold,
  input  logic [DATA_OUT_WIDTH-1:0] fir_data_out
);

  localparam int unsigned WptrW = $clog2(ORDER + 1);
  localparam int unsigned KW    = $clog2(ORDER);
  localparam logic [WptrW-1:0] WptrFull = WptrW'(ORDER);
  localparam logic [KW-1:0]    KLast    = KW'(ORDER - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [WptrW-1:0]        wptr_q, wptr_d;
  logic [KW-1:0]           kcnt_q, kcnt_d;
  logic                    primed_q, primed_d;
  logic                    err_q, err_d;
  logic                    stop_q, stop_d;
  logic                    m_valid_q, m_valid_d;
  logic [RESULT_WIDTH-1:0] m_data_q, m_data_d;
  logic [COEF_WIDTH-1:0]   shadow_q [ORDER];

  logic                    out_free, fire, drain_cap, capture, commit_ok, shadow_we;
  logic [RESULT_WIDTH-1:0] res;
  logic                    unused_in;

  assign unused_in = ^{fir_hold, fir_data_out};

  assign out_free  = !m_valid_q || m_ready;
  assign commit_ok = cfg_commit && (wptr_q == WptrFull);
  assign fire      = (state_q == StRun) && fir_start && fir_run;
  assign drain_cap = (state_q == StDrain) && primed_q && fir_start && out_free;
  assign capture   = (fire && primed_q) || drain_cap;
  assign shadow_we = (state_q == StIdle) && cfg_coef_wr && !cfg_commit && (wptr_q != WptrFull);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (commit_ok) state_d = StLoad;
      StLoad:  if (kcnt_q == KLast) state_d = StRun;
      StRun:   if (fir_start && stop_q) state_d = StDrain;
      StDrain: if (!primed_q || drain_cap) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fir_coef_shift_en = 1'b0;
    fir_coef_in       = '0;
    fir_run           = 1'b0;
    fir_data_in       = '0;
    s_ready           = 1'b0;
    unique case (state_q)
      StLoad: begin
        fir_coef_shift_en = 1'b1;
        fir_coef_in       = shadow_q[kcnt_q];
      end
      StRun: begin
        fir_data_in = s_data;
        if (!fir_start) begin
          fir_run = 1'b1;
        end else if (!stop_q) begin
          // Before the first sample the core output is meaningless, so no sink space is needed.
          fir_run = s_valid && (out_free || !primed_q);
          s_ready = fir_run;
        end
      end
      StDrain: begin
        if (primed_q) fir_run = !fir_start || out_free;
      end
      default: ;
    endcase
  end

  always_comb begin
    wptr_d    = wptr_q;
    err_d     = err_q;
    primed_d  = primed_q;
    kcnt_d    = '0;
    stop_d    = (state_q == StRun) && (state_d == StRun) && (stop_q || cfg_stop);
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (state_q == StIdle) begin
      if (cfg_commit) begin
        wptr_d = '0;
        err_d  = !commit_ok;
        if (commit_ok) primed_d = 1'b0;
      end else if (cfg_coef_wr) begin
        if (wptr_q == WptrFull) err_d = 1'b1;
        else                    wptr_d = wptr_q + 1'b1;
      end
    end
    if (state_q == StLoad) kcnt_d = kcnt_q + 1'b1;
    if (fire) primed_d = 1'b1;
    if (state_q == StDrain && state_d == StIdle) primed_d = 1'b0;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (capture) begin
      m_valid_d = 1'b1;
      m_data_d  = res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      kcnt_q    <= '0;
      primed_q  <= 1'b0;
      err_q     <= 1'b0;
      stop_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      wptr_q    <= wptr_d;
      kcnt_q    <= kcnt_d;
      primed_q  <= primed_d;
      err_q     <= err_d;
      stop_q    <= stop_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  // Shadow bank has no reset; it is always rewritten before a commit is accepted.
  always_ff @(posedge clk) begin
    if (shadow_we) shadow_q[wptr_q] <= cfg_coef_data;
  end

`ifdef FIR_SEQ_DRV_SAT_EN
  localparam logic [DATA_OUT_WIDTH:0] One  = (DATA_OUT_WIDTH + 1)'(1);
  localparam logic [DATA_OUT_WIDTH:0] UMax = (One << RESULT_WIDTH) - One;
  localparam logic [DATA_OUT_WIDTH:0] SMax = (One << (RESULT_WIDTH - 1)) - One;
  localparam logic [DATA_OUT_WIDTH:0] SMin = ~SMax;

  logic [DATA_OUT_WIDTH:0] ext;

  always_comb begin
    ext = {tc & fir_data_out[DATA_OUT_WIDTH-1], fir_data_out};
    res = fir_data_out[RESULT_WIDTH-1:0];
    if (tc) begin
      if ($signed(ext) > $signed(SMax))      res = SMax[RESULT_WIDTH-1:0];
      else if ($signed(ext) < $signed(SMin)) res = SMin[RESULT_WIDTH-1:0];
    end else if (ext > UMax) begin
      res = UMax[RESULT_WIDTH-1:0];
    end
  end
`else
  assign res = fir_data_out[RESULT_WIDTH-1:0];
`endif

  assign cfg_busy         = (state_q != StIdle);
  assign cfg_err          = err_q;
  assign m_valid          = m_valid_q;
  assign m_data           = m_data_q;
  assign fir_tc           = tc;
  assign fir_init_acc_val = '0;

endmodule

// File: tb/tb_fir_seq_driver.sv
// Directed bench for fir_seq_driver with a small sequential-FIR core model whose result is
// 10x the sample taken at the previous boundary.
module tb_fir_seq_driver;

  localparam int unsigned DIW   = 8;
  localparam int unsigned CW    = 8;
  localparam int unsigned DOW   = 18;
  localparam int unsigned ORDER = 6;
  localparam int unsigned RW    = 8;

`ifdef FIR_SEQ_DRV_SAT_EN
  localparam int unsigned E100 = 100, E200 = 127, E300 = 127, E400 = 127;
`else
  localparam int unsigned E100 = 100, E200 = 200, E300 = 44, E400 = 144;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           tc = 1'b1;
  logic           cfg_coef_wr = 1'b0;
  logic [CW-1:0]  cfg_coef_data = '0;
  logic           cfg_commit = 1'b0;
  logic           cfg_stop = 1'b0;
  logic           cfg_busy, cfg_err;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [DIW-1:0] s_data = '0;
  logic           m_valid;
  logic           m_ready = 1'b0;
  logic [RW-1:0]  m_data;
  logic           fir_coef_shift_en, fir_tc, fir_run, fir_start;
  logic [CW-1:0]  fir_coef_in;
  logic [DIW-1:0] fir_data_in;
  logic [DOW-1:0] fir_init_acc_val;
  logic [DOW-1:0] core_out;
  logic [2:0]     core_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int load_run_viol = 0;
  int core_q[$];
  int res_q[$];
  int coef_q[$];

  always #5 clk = ~clk;

  fir_seq_driver #(
    .DATA_IN_WIDTH(DIW), .COEF_WIDTH(CW), .DATA_OUT_WIDTH(DOW), .ORDER(ORDER), .RESULT_WIDTH(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tc(tc),
    .cfg_coef_wr(cfg_coef_wr), .cfg_coef_data(cfg_coef_data),
    .cfg_commit(cfg_commit), .cfg_stop(cfg_stop), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fir_coef_shift_en(fir_coef_shift_en), .fir_coef_in(fir_coef_in), .fir_tc(fir_tc),
    .fir_run(fir_run), .fir_data_in(fir_data_in), .fir_init_acc_val(fir_init_acc_val),
    .fir_start(fir_start), .fir_hold(1'b0), .fir_data_out(core_out)
  );

  // Core model: boundary at count 0, advances only while run is high.
  assign fir_start = (core_cnt == 3'd0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_cnt <= 3'd0;
      core_out <= '0;
    end else if (fir_run) begin
      core_cnt <= (core_cnt == 3'(ORDER - 1)) ? 3'd0 : core_cnt + 3'd1;
      if (fir_start) core_out <= DOW'(fir_data_in) * DOW'(10);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (fir_start && fir_run) core_q.push_back(int'(fir_data_in));
      if (m_valid && m_ready)   res_q.push_back(int'(m_data));
      if (fir_coef_shift_en)    coef_q.push_back(int'(fir_coef_in));
      if (fir_coef_shift_en && fir_run) load_run_viol++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int v);
    cfg_coef_wr   = 1'b1;
    cfg_coef_data = CW'(v);
    tick();
    cfg_coef_wr = 1'b0;
  endtask

  task automatic pulse_commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic send(input int v);
    logic got;
    bit   done = 1'b0;
    s_valid = 1'b1;
    s_data  = DIW'(v);
    for (int i = 0; i < 200; i++) begin
      #1;
      got = s_ready;
      tick();
      if (got) begin
        done = 1'b1;
        break;
      end
    end
    s_valid = 1'b0;
    check_eq("send_timeout", 32'(!done), 0);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!cfg_busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check_eq("idle_timeout", 32'(!done), 0);
  endtask

  initial begin
    int viol;
    int seen;

    #3;
    check_eq("rst_busy", 32'(cfg_busy), 0);
    check_eq("rst_err", 32'(cfg_err), 0);
    check_eq("rst_s_ready", 32'(s_ready), 0);
    check_eq("rst_m_valid", 32'(m_valid), 0);
    check_eq("rst_m_data", 32'(m_data), 0);
    check_eq("rst_run", 32'(fir_run), 0);
    check_eq("rst_shift_en", 32'(fir_coef_shift_en), 0);
    check_eq("rst_coef_in", 32'(fir_coef_in), 0);
    check_eq("rst_data_in", 32'(fir_data_in), 0);
    check_eq("init_acc", 32'(fir_init_acc_val), 0);
    tick();
    rst_n = 1'b1;
    tick();

    tc = 1'b0;
    #1 check_eq("tc_pass0", 32'(fir_tc), 0);
    tc = 1'b1;
    #1 check_eq("tc_pass1", 32'(fir_tc), 1);

    // Short commit is rejected.
    for (int i = 1; i <= 5; i++) write_coef(i + 50);
    pulse_commit();
    check_eq("short_commit_err", 32'(cfg_err), 1);
    check_eq("short_commit_idle", 32'(cfg_busy), 0);

    // Overflow write is dropped; load sequence proves shadow unchanged.
    for (int i = 1; i <= 6; i++) write_coef(i);
    write_coef(99);
    check_eq("overflow_err", 32'(cfg_err), 1);
    pulse_commit();
    check_eq("commit_err_clr", 32'(cfg_err), 0);
    check_eq("load_busy", 32'(cfg_busy), 1);
    check_eq("load_shift_lat", 32'(fir_coef_shift_en), 1);
    check_eq("load_first_coef", 32'(fir_coef_in), 1);
    check_eq("load_run_low", 32'(fir_run), 0);
    repeat (ORDER) tick();
    check_eq("load_done", 32'(fir_coef_shift_en), 0);
    check_eq("load_count", 32'(coef_q.size()), ORDER);
    for (int i = 0; i < coef_q.size() && i < 6; i++) check_eq("load_coef", 32'(coef_q[i]), i + 1);
    check_eq("load_run_viol", 32'(load_run_viol), 0);
    check_eq("run_busy", 32'(cfg_busy), 1);

    m_ready = 1'b1;
    send(10);
    check_eq("no_result_first", 32'(m_valid), 0);
    send(20);
    check_eq("res1_valid", 32'(m_valid), 1);
    check_eq("res1_data", 32'(m_data), E100);
    send(30);
    check_eq("res2_data", 32'(m_data), E200);

    // Sink stalled with a result pending: core must be held at the boundary.
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = DIW'(40);
    viol = 0;
    seen = 0;
    for (int i = 0; i < 2 * ORDER; i++) begin
      #1;
      if (fir_start) begin
        seen++;
        if (fir_run || s_ready) viol++;
      end
      tick();
    end
    check_eq("stall_seen", 32'(seen > 0), 1);
    check_eq("stall_hold", 32'(viol), 0);
    check_eq("stall_keep", 32'(m_data), E200);
    m_ready = 1'b1;
    send(40);
    check_eq("cap_pop_valid", 32'(m_valid), 1);
    check_eq("cap_pop_data", 32'(m_data), E300);

    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    wait_idle();
    repeat (3) tick();
    check_eq("stop_busy", 32'(cfg_busy), 0);
    check_eq("core_count", 32'(core_q.size()), 5);
    if (core_q.size() == 5) begin
      check_eq("core_s3", 32'(core_q[3]), 40);
      check_eq("core_dummy", 32'(core_q[4]), 0);
    end
    check_eq("res_count", 32'(res_q.size()), 4);
    if (res_q.size() == 4) begin
      check_eq("res_q1", 32'(res_q[1]), E200);
      check_eq("res_q2", 32'(res_q[2]), E300);
      check_eq("res_q3", 32'(res_q[3]), E400);
    end

    // Stop before any sample: straight back to IDLE, nothing emitted.
    for (int i = 0; i < 6; i++) write_coef(7);
    pulse_commit();
    repeat (ORDER) tick();
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    wait_idle();
    repeat (3) tick();
    check_eq("empty_stop_busy", 32'(cfg_busy), 0);
    check_eq("empty_stop_valid", 32'(m_valid), 0);
    check_eq("empty_stop_core", 32'(core_q.size()), 5);
    check_eq("empty_stop_res", 32'(res_q.size()), 4);
    check_eq("empty_stop_err", 32'(cfg_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1, expected 0");
    $fatal(1, "timeout");
  end

endmodule
